// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the Simple CPU v1 control path:
// opcode values, ALU operation codes and controller state encoding.
package cpu_ctrl_pkg;

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_LDA = 8'h01;
    localparam logic [7:0] OP_STA = 8'h02;
    localparam logic [7:0] OP_ADD = 8'h03;
    localparam logic [7:0] OP_SUB = 8'h04;
    localparam logic [7:0] OP_JMP = 8'h05;
    localparam logic [7:0] OP_JZ  = 8'h06;
    localparam logic [7:0] OP_HLT = 8'hFF;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;

    typedef enum logic [1:0] {
        FETCH_OP  = 2'd0,
        FETCH_ARG = 2'd1,
        EXEC      = 2'd2,
        HALT      = 2'd3
    } state_e;

endpackage

// File: rtl/cpu_ctrl_op_decode.sv
// Combinational opcode decoder: maps an opcode byte to the
// instruction attributes the control FSM needs.
module op_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int OPW = 8
) (
    input  logic [OPW-1:0] op,
    output logic           two_byte,
    output logic           is_mem_rd,
    output logic           is_mem_wr,
    output logic           is_jmp,
    output logic           is_jz,
    output logic           is_hlt,
    output logic           is_illegal,
    output logic [1:0]     alu_op
);

    always_comb begin
        two_byte   = 1'b0;
        is_mem_rd  = 1'b0;
        is_mem_wr  = 1'b0;
        is_jmp     = 1'b0;
        is_jz      = 1'b0;
        is_hlt     = 1'b0;
        is_illegal = 1'b0;
        alu_op     = ALU_PASS;
        unique case (op)
            OP_NOP: ;
            OP_LDA: begin
                two_byte  = 1'b1;
                is_mem_rd = 1'b1;
                alu_op    = ALU_PASS;
            end
            OP_STA: begin
                two_byte  = 1'b1;
                is_mem_wr = 1'b1;
            end
            OP_ADD: begin
                two_byte  = 1'b1;
                is_mem_rd = 1'b1;
                alu_op    = ALU_ADD;
            end
            OP_SUB: begin
                two_byte  = 1'b1;
                is_mem_rd = 1'b1;
                alu_op    = ALU_SUB;
            end
            OP_JMP: begin
                two_byte = 1'b1;
                is_jmp   = 1'b1;
            end
            OP_JZ: begin
                two_byte = 1'b1;
                is_jz    = 1'b1;
            end
            OP_HLT: is_hlt = 1'b1;
            default: is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl.sv
// Multi-cycle control FSM for the Simple CPU v1: sequences opcode
// fetch, operand fetch and execute against a mem_rdy handshake.
module cpu_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int OPW = 8,
    parameter int DW  = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic [DW-1:0] mem_din,
    input  logic          mem_rdy,
    input  logic          zero,
    output logic          muxc,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic          pc_inc,
    output logic          pc_ld,
    output logic          ir_ld,
    output logic          acc_ld,
    output logic [1:0]    alu_op,
    output logic          halted,
    output logic          illegal
);

    state_e         state_q, state_d;
    logic [OPW-1:0] opcode_q, opcode_d;
    logic           blank_q;

    logic [OPW-1:0] dec_op;
    logic           d_two_byte;
    logic           d_mem_rd;
    logic           d_mem_wr;
    logic           d_jmp;
    logic           d_jz;
    logic           d_hlt;
    logic           d_illegal;
    logic [1:0]     d_alu_op;

    // During opcode fetch the decision needs the byte on the bus,
    // afterwards the captured opcode.
    assign dec_op = (state_q == FETCH_OP) ? mem_din[OPW-1:0] : opcode_q;

    op_decode #(.OPW(OPW)) u_dec (
        .op         (dec_op),
        .two_byte   (d_two_byte),
        .is_mem_rd  (d_mem_rd),
        .is_mem_wr  (d_mem_wr),
        .is_jmp     (d_jmp),
        .is_jz      (d_jz),
        .is_hlt     (d_hlt),
        .is_illegal (d_illegal),
        .alu_op     (d_alu_op)
    );

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        muxc     = 1'b0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        pc_inc   = 1'b0;
        pc_ld    = 1'b0;
        ir_ld    = 1'b0;
        acc_ld   = 1'b0;
        alu_op   = ALU_PASS;
        halted   = 1'b0;
        illegal  = 1'b0;
        // Outputs stay quiet during reset and the cycle right after it.
        if (!(rst || blank_q)) begin
            unique case (state_q)
                FETCH_OP: begin
                    if (run) begin
                        mem_rd = 1'b1;
                        if (mem_rdy) begin
                            pc_inc   = 1'b1;
                            opcode_d = dec_op;
                            state_d  = d_two_byte ? FETCH_ARG : EXEC;
                        end
                    end
                end
                FETCH_ARG: begin
                    mem_rd = 1'b1;
                    if (mem_rdy) begin
                        ir_ld   = 1'b1;
                        pc_inc  = 1'b1;
                        state_d = EXEC;
                    end
                end
                EXEC: begin
                    if (d_mem_rd) begin
                        muxc   = 1'b1;
                        mem_rd = 1'b1;
                        alu_op = d_alu_op;
                        if (mem_rdy) begin
                            acc_ld  = 1'b1;
                            state_d = FETCH_OP;
                        end
                    end else if (d_mem_wr) begin
                        muxc   = 1'b1;
                        mem_wr = 1'b1;
                        if (mem_rdy) state_d = FETCH_OP;
                    end else if (d_jmp) begin
                        pc_ld   = 1'b1;
                        state_d = FETCH_OP;
                    end else if (d_jz) begin
                        pc_ld   = zero;
                        state_d = FETCH_OP;
                    end else if (d_hlt || d_illegal) begin
                        state_d = HALT;
                    end else begin
                        state_d = FETCH_OP;
                    end
                end
                HALT: begin
                    halted  = 1'b1;
                    illegal = d_illegal;
                end
                default: state_d = FETCH_OP;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FETCH_OP;
            opcode_q <= '0;
            blank_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            blank_q  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Self-checking bench for cpu_ctrl: per-instruction expected
// output traces plus a small PC/IR datapath model.
module tb_cpu_ctrl;

    logic       clk;
    logic       rst;
    logic       run;
    logic [7:0] mem_din;
    logic       mem_rdy;
    logic       zero;
    logic       muxc, mem_rd, mem_wr, pc_inc, pc_ld;
    logic       ir_ld, acc_ld, halted, illegal;
    logic [1:0] alu_op;

    cpu_ctrl #(.OPW(8), .DW(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .mem_din (mem_din),
        .mem_rdy (mem_rdy),
        .zero    (zero),
        .muxc    (muxc),
        .mem_rd  (mem_rd),
        .mem_wr  (mem_wr),
        .pc_inc  (pc_inc),
        .pc_ld   (pc_ld),
        .ir_ld   (ir_ld),
        .acc_ld  (acc_ld),
        .alu_op  (alu_op),
        .halted  (halted),
        .illegal (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [10:0] V0  = 11'h000;
    localparam logic [10:0] MX  = 11'h400;
    localparam logic [10:0] RD  = 11'h200;
    localparam logic [10:0] WR  = 11'h100;
    localparam logic [10:0] INC = 11'h080;
    localparam logic [10:0] PCL = 11'h040;
    localparam logic [10:0] IRL = 11'h020;
    localparam logic [10:0] ACC = 11'h010;
    localparam logic [10:0] HLT = 11'h002;
    localparam logic [10:0] ILL = 11'h001;

    function automatic logic [10:0] alu_v(input logic [1:0] a);
        return {7'b0, a, 2'b00};
    endfunction

    logic [10:0] dut_vec;
    assign dut_vec = {muxc, mem_rd, mem_wr, pc_inc, pc_ld, ir_ld,
                      acc_ld, alu_op, halted, illegal};

    logic [10:0] exp_vec;
    logic        exp_valid;
    logic        pc_req;
    logic [7:0]  pc_exp;
    int          n_chk;
    int          n_pass;

    logic [7:0] dp_pc;
    logic [7:0] dp_ir;

    always @(posedge clk) begin
        if (rst) begin
            dp_pc <= 8'h00;
            dp_ir <= 8'h00;
        end else begin
            if (pc_ld) dp_pc <= dp_ir;
            else if (pc_inc) dp_pc <= dp_pc + 8'h01;
            if (ir_ld) dp_ir <= mem_din;
        end
    end

    initial begin
        n_chk  = 0;
        n_pass = 0;
    end

    always @(negedge clk) begin
        if (exp_valid) begin
            n_chk++;
            if (dut_vec !== exp_vec)
                $display("FAIL outputs t=%0t got %b want %b",
                         $time, dut_vec, exp_vec);
            else
                n_pass++;
        end
        if (pc_req) begin
            n_chk++;
            if (dp_pc !== pc_exp)
                $display("FAIL pc t=%0t got %h want %h",
                         $time, dp_pc, pc_exp);
            else
                n_pass++;
        end
    end

    task automatic step(input logic r, input logic ru, input logic rdy,
                        input logic z, input logic [7:0] din,
                        input logic [10:0] e);
        rst       = r;
        run       = ru;
        mem_rdy   = rdy;
        zero      = z;
        mem_din   = din;
        exp_vec   = e;
        exp_valid = 1'b1;
        @(posedge clk);
        #1;
        pc_req = 1'b0;
    endtask

    task automatic pc_check(input logic [7:0] v);
        pc_exp = v;
        pc_req = 1'b1;
    endtask

    // One instruction, w wait cycles per memory phase; ra is run
    // after the opcode fetch.
    task automatic instr(input logic [7:0] op, input logic [7:0] arg,
                         input logic z, input int w, input logic ra);
        logic [10:0] av;
        repeat (w) step(1'b0, 1'b1, 1'b0, z, op, RD);
        step(1'b0, 1'b1, 1'b1, z, op, RD | INC);
        if (op inside {[8'h01:8'h06]}) begin
            repeat (w) step(1'b0, ra, 1'b0, z, arg, RD);
            step(1'b0, ra, 1'b1, z, arg, RD | INC | IRL);
        end
        case (op)
            8'h01, 8'h03, 8'h04: begin
                av = alu_v(op == 8'h01 ? 2'b00 :
                           op == 8'h03 ? 2'b01 : 2'b10);
                repeat (w) step(1'b0, ra, 1'b0, z, 8'h5A, MX | RD | av);
                step(1'b0, ra, 1'b1, z, 8'h5A, MX | RD | av | ACC);
            end
            8'h02: begin
                repeat (w) step(1'b0, ra, 1'b0, z, 8'h00, MX | WR);
                step(1'b0, ra, 1'b1, z, 8'h00, MX | WR);
            end
            8'h05: step(1'b0, ra, 1'b1, z, 8'h00, PCL);
            8'h06: step(1'b0, ra, 1'b1, z, 8'h00, z ? PCL : V0);
            default: step(1'b0, ra, 1'b1, z, 8'h00, V0);
        endcase
    endtask

    initial begin
        rst       = 1'b1;
        run       = 1'b0;
        mem_rdy   = 1'b0;
        zero      = 1'b0;
        mem_din   = 8'h00;
        exp_vec   = V0;
        exp_valid = 1'b0;
        pc_req    = 1'b0;
        pc_exp    = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        repeat (2) step(1'b1, 1'b0, 1'b1, 1'b0, 8'h01, V0);
        pc_check(8'h00);
        repeat (5) step(1'b0, 1'b0, 1'b1, 1'b0, 8'h01, V0);

        instr(8'h01, 8'h20, 1'b0, 0, 1'b1);
        pc_check(8'h02);
        instr(8'h02, 8'h30, 1'b0, 3, 1'b1);
        instr(8'h03, 8'h31, 1'b0, 3, 1'b1);
        pc_check(8'h06);
        instr(8'h06, 8'h40, 1'b1, 0, 1'b1);
        pc_check(8'h40);
        instr(8'h06, 8'h50, 1'b0, 0, 1'b1);
        pc_check(8'h42);
        instr(8'h05, 8'h10, 1'b0, 0, 1'b1);
        pc_check(8'h10);
        instr(8'h00, 8'h00, 1'b0, 0, 1'b1);
        pc_check(8'h11);
        instr(8'h04, 8'h22, 1'b0, 1, 1'b0);
        pc_check(8'h13);
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0, 8'h01, V0);

        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h01, RD | INC);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h55, RD | INC | IRL);
        repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0, 8'h5A, MX | RD);
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h5A, V0);
        pc_check(8'h00);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, V0);
        instr(8'h00, 8'h00, 1'b0, 0, 1'b1);
        pc_check(8'h01);

        instr(8'hFF, 8'h00, 1'b0, 0, 1'b1);
        repeat (20) step(1'b0, 1'b1, 1'b1, 1'b0, 8'h01, HLT);
        step(1'b1, 1'b1, 1'b1, 1'b0, 8'h01, V0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h01, V0);

        instr(8'h7E, 8'h00, 1'b0, 1, 1'b1);
        repeat (5) step(1'b0, 1'b1, 1'b1, 1'b0, 8'h01, HLT | ILL);
        step(1'b1, 1'b1, 1'b1, 1'b0, 8'h01, V0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h01, V0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h01, V0);

        exp_valid = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
